// File: rtl/s1_sequenciador_pontos.sv
// s1_sequenciador_pontos
//   Scoring-phase controller for the S1 game datapath. After a start pulse it
//   walks the per-round error memory (MemErro) from address 0 up to the latched
//   last round, subtracting PENALIDADE points per error from a score that starts
//   at PONTOS_INICIAIS and saturates at 0. Pulses `pronto` when the walk ends.
//
//   Optional feature (macro S1_BONUS_PERFEITO_EN): a zero-error round adds BONUS
//   points, capped at PONTOS_INICIAIS, instead of leaving the score unchanged.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   iniciar        start pulse, sampled only while idle
//   ultima_rodada  index of the last valid round, latched when the start is accepted
//   mem_endereco   MemErro read address (registered)
//   mem_dado       MemErro read data, valid MEM_LAT cycles after the address changes
//   pontos         running / final score
//   ocupado        high from CARREGA through FIM
//   pronto         one-cycle pulse while in FIM
//   db_estado      current state encoding
module s1_sequenciador_pontos #(
  parameter int unsigned ADDR_W          = 4,
  parameter int unsigned ERR_W           = 4,
  parameter int unsigned PONTOS_W        = 7,
  parameter int unsigned PONTOS_INICIAIS = 100,
  parameter int unsigned PENALIDADE      = 5,
  parameter int unsigned MEM_LAT         = 1,
  parameter int unsigned BONUS           = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [ADDR_W-1:0]   ultima_rodada,
  output logic [ADDR_W-1:0]   mem_endereco,
  input  logic [ERR_W-1:0]    mem_dado,
  output logic [PONTOS_W-1:0] pontos,
  output logic                ocupado,
  output logic                pronto,
  output logic [2:0]          db_estado
);

  // MEM_LAT is limited to 1..3, so a 2-bit wait counter is enough.
  localparam int unsigned CNT_W  = 2;
  // Wide enough that the penalty product and the bonus sum can never wrap.
  localparam int unsigned CALC_W = ERR_W + 32;

`ifdef S1_BONUS_PERFEITO_EN
  localparam bit BONUS_EN = 1'b1;
`else
  localparam bit BONUS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ESPERA  = 3'd2,
    ACUMULA = 3'd3,
    FIM     = 3'd4
  } estado_t;

  estado_t             state, state_next;
  logic [ADDR_W-1:0]   limite, limite_next;
  logic [ADDR_W-1:0]   endereco_next;
  logic [PONTOS_W-1:0] pontos_next, pontos_acum;
  logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
  logic                ocupado_next, pronto_next;
  logic [CALC_W-1:0]   desconto, pontos_ext, pontos_bonus;

  // Score update for the current MemErro entry: saturating penalty, optional bonus.
  always_comb begin
    desconto     = CALC_W'(mem_dado) * CALC_W'(PENALIDADE);
    pontos_ext   = CALC_W'(pontos);
    pontos_bonus = pontos_ext + CALC_W'(BONUS);
    pontos_acum  = pontos;
    if (BONUS_EN && (mem_dado == '0)) begin
      if (pontos_bonus >= CALC_W'(PONTOS_INICIAIS)) begin
        pontos_acum = PONTOS_W'(PONTOS_INICIAIS);
      end else begin
        pontos_acum = PONTOS_W'(pontos_bonus);
      end
    end else if (desconto >= pontos_ext) begin
      pontos_acum = '0;
    end else begin
      pontos_acum = PONTOS_W'(pontos_ext - desconto);
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_next    = state;
    limite_next   = limite;
    endereco_next = mem_endereco;
    pontos_next   = pontos;
    cnt_next      = cnt;
    cnt_inc       = cnt + CNT_W'(1);
    unique case (state)
      OCIOSO: begin
        if (iniciar) begin
          limite_next = ultima_rodada;
          state_next  = CARREGA;
        end
      end
      CARREGA: begin
        pontos_next   = PONTOS_W'(PONTOS_INICIAIS);
        endereco_next = '0;
        cnt_next      = '0;
        state_next    = ESPERA;
      end
      ESPERA: begin
        cnt_next = cnt_inc;
        if (cnt_inc == CNT_W'(MEM_LAT)) begin
          state_next = ACUMULA;
        end
      end
      ACUMULA: begin
        pontos_next = pontos_acum;
        // Terminate on equality so a full-range walk never wraps the address.
        if (mem_endereco == limite) begin
          state_next = FIM;
        end else begin
          endereco_next = mem_endereco + ADDR_W'(1);
          cnt_next      = '0;
          state_next    = ESPERA;
        end
      end
      FIM: begin
        state_next = OCIOSO;
      end
      default: begin
        state_next = OCIOSO;
      end
    endcase
    ocupado_next = (state_next != OCIOSO);
    pronto_next  = (state_next == FIM);
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= OCIOSO;
      limite       <= '0;
      mem_endereco <= '0;
      pontos       <= PONTOS_W'(PONTOS_INICIAIS);
      cnt          <= '0;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
    end else begin
      state        <= state_next;
      limite       <= limite_next;
      mem_endereco <= endereco_next;
      pontos       <= pontos_next;
      cnt          <= cnt_next;
      ocupado      <= ocupado_next;
      pronto       <= pronto_next;
    end
  end

  assign db_estado = state;

endmodule
